reservation_station: RTL and testbench
======================================

RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 Parameter DEPTH, default 4: number of entries, 2..16.
REQ-002 Parameter XLEN, default 64: operand/value width.
REQ-003 Parameter TAG_W, default 3: producer tag width; tag 0 is reserved as "no producer".
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 flush  in  1  discard all entries.
REQ-007 issue_valid  in  1, issue_ready  out  1: issue handshake.
REQ-008 issue_op  in  19: {format[1:0], funct7[6:0], funct3[2:0], opcode[6:0]}.
REQ-009 issue_imm  in  12, issue_dest_tag  in  TAG_W: immediate and result tag.
REQ-010 issue_rsN_virtual  in  1, issue_rsN_tag  in  TAG_W, issue_rsN_value  in  XLEN, for N=1,2: operand is either a pending tag or a value.
REQ-011 cdb_valid  in  1, cdb_tag  in  TAG_W, cdb_value  in  XLEN: result broadcast.
REQ-012 disp_valid  out  1, disp_ready  in  1: dispatch handshake to the functional unit.
REQ-013 disp_op  out  19, disp_imm  out  12, disp_dest_tag  out  TAG_W, disp_a  out  XLEN, disp_b  out  XLEN: dispatched payload.
REQ-014 occupancy  out  $clog2(DEPTH+1): number of valid entries.

Function
REQ-015 Each entry SHALL hold: valid, op, imm, dest_tag, and per operand {pending, tag, value}.
REQ-016 issue_ready SHALL be 1 iff at least one entry is invalid; a full station that dispatches in the same cycle does not assert issue_ready.
REQ-017 On issue_valid&&issue_ready the lowest-index invalid entry SHALL be written; the entry is valid from the next cycle.
REQ-018 An issued operand SHALL be stored pending iff virtual=1 and the same-cycle CDB does not match its tag; on a match it is stored as cdb_value with pending=0.
REQ-019 Each cycle, every valid entry operand that is pending with tag==cdb_tag under cdb_valid SHALL capture cdb_value and clear pending.
REQ-020 An entry is ready when both operands are non-pending; format I ignores rs2 pending state, and format R ignores imm.
REQ-021 disp_valid SHALL be 1 iff any entry is ready; the selected entry is the lowest-index ready entry, and disp_* reflect it combinationally.
REQ-022 On disp_valid&&disp_ready the selected entry SHALL be invalidated at the edge.
REQ-023 Issue and dispatch in the same cycle SHALL both take effect; the freed slot is not reusable until the next cycle.
REQ-024 occupancy SHALL equal the popcount of the valid bits, updated registered: +1 on issue, -1 on dispatch, unchanged when both occur.
REQ-025 A cdb_tag of 0 SHALL wake nothing.
REQ-026 flush SHALL invalidate all entries at the edge and suppress a same-cycle issue write; disp_valid still reflects pre-flush state in that cycle.

Reset
REQ-027 On rst all entries SHALL be invalid, occupancy=0, disp_valid=0, and issue_ready=1 from the next cycle; rst overrides issue, CDB and flush.
REQ-028 Entry payload fields need not be reset; disp_* other than disp_valid are don't-care while disp_valid=0.

Configuration
REQ-029 Macro RS_WAKEUP_BYPASS_EN.
- Defined: an entry whose last pending operand matches the current CDB broadcast SHALL be ready in that same cycle, with cdb_value muxed into disp_a/disp_b (zero-cycle wakeup).
- Undefined: that entry becomes ready the cycle after capture (one-cycle wakeup), with no CDB-to-disp combinational path.
REQ-030 Both configurations SHALL satisfy every other requirement unchanged.

Verification
REQ-031 Reset, then issue 4 ops with both operands as values (DEPTH=4), disp_ready=0 -> issue_ready=0 after the 4th, occupancy=4, and disp_op equals the op in entry 0.
REQ-032 Issue with rs1 virtual tag 5, then cdb_valid tag=5 value=0x1234 two cycles later -> disp_a=0x1234; disp_valid rises in the CDB cycle with the bypass macro, and one cycle later without it.
REQ-033 Issue with rs1 tag 3 while the same cycle carries cdb tag=3 value=0xAA -> the entry is stored non-pending and dispatches disp_a=0xAA.
REQ-034 Full station, simultaneous issue_valid and dispatch -> issue is not accepted and occupancy goes 4->3; an issue the following cycle is accepted into the freed slot.
REQ-035 Three entries pending on tag 2, then flush asserted together with cdb tag=2 -> all entries invalid, occupancy=0, and no dispatch follows.
REQ-036 Issue an entry pending on tag 0 and broadcast cdb tag=0 -> the entry stays pending and disp_valid=0.

Source files
------------

// File: rtl/reservation_station.sv
// -----------------------------------------------------------------------------
// reservation_station
//
// An operand-tracking reservation station that sits between issue and one
// functional unit. Each entry holds an op, an immediate, a result tag and two
// operands. Each operand is either a known value or pending on a producer tag.
// Pending operands capture results broadcast on the common data bus (CDB).
// The lowest-index entry whose operands are all available is offered to the
// functional unit.
//
// Format field (op[18:17]) encoding used here:
//   2'b00 R-type: both operands are required; imm is carried but unused.
//   2'b01 I-type: only rs1 is required; the rs2 pending state is ignored.
//   others      : both operands are required.
//
// Optional feature macro: RS_WAKEUP_BYPASS_EN
//   defined   - zero-cycle wakeup. An entry whose last pending operand matches
//               the current CDB broadcast is ready in that same cycle, and
//               cdb_value_i is muxed into disp_a_o/disp_b_o.
//   undefined - one-cycle wakeup. There is no CDB-to-dispatch combinational
//               path.
//
// Ports
//   clk_i, rst_i               clock; synchronous active-high reset
//   flush_i                    drop every entry at the next edge
//   issue_valid_i/ready_o      issue handshake
//   issue_op_i                 {format[1:0], funct7, funct3, opcode}
//   issue_imm_i, issue_dest_tag_i
//   issue_rs{1,2}_virtual_i    1: operand is pending on issue_rs{1,2}_tag_i
//   issue_rs{1,2}_tag_i/value_i
//   cdb_valid_i/tag_i/value_i  result broadcast; tag 0 wakes nothing
//   disp_valid_o/ready_i       dispatch handshake
//   disp_op_o, disp_imm_o, disp_dest_tag_o, disp_a_o, disp_b_o
//   occupancy_o                number of valid entries
// -----------------------------------------------------------------------------
module reservation_station #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 3
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,

    input  logic                           issue_valid_i,
    output logic                           issue_ready_o,
    input  logic [18:0]                    issue_op_i,
    input  logic [11:0]                    issue_imm_i,
    input  logic [TAG_W-1:0]               issue_dest_tag_i,
    input  logic                           issue_rs1_virtual_i,
    input  logic [TAG_W-1:0]               issue_rs1_tag_i,
    input  logic [XLEN-1:0]                issue_rs1_value_i,
    input  logic                           issue_rs2_virtual_i,
    input  logic [TAG_W-1:0]               issue_rs2_tag_i,
    input  logic [XLEN-1:0]                issue_rs2_value_i,

    input  logic                           cdb_valid_i,
    input  logic [TAG_W-1:0]               cdb_tag_i,
    input  logic [XLEN-1:0]                cdb_value_i,

    output logic                           disp_valid_o,
    input  logic                           disp_ready_i,
    output logic [18:0]                    disp_op_o,
    output logic [11:0]                    disp_imm_o,
    output logic [TAG_W-1:0]               disp_dest_tag_o,
    output logic [XLEN-1:0]                disp_a_o,
    output logic [XLEN-1:0]                disp_b_o,

    output logic [$clog2(DEPTH+1)-1:0]     occupancy_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam logic [1:0]  FMT_I = 2'b01;

    // Entry state: only the valid bits are reset; payload is qualified by valid.
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [18:0]       op_q   [DEPTH];
    logic [11:0]       imm_q  [DEPTH];
    logic [TAG_W-1:0]  dest_q [DEPTH];
    logic [DEPTH-1:0]  p1_q, p2_q;
    logic [TAG_W-1:0]  t1_q   [DEPTH];
    logic [TAG_W-1:0]  t2_q   [DEPTH];
    logic [XLEN-1:0]   v1_q   [DEPTH];
    logic [XLEN-1:0]   v2_q   [DEPTH];

    logic [OCC_W-1:0]  occ_q, occ_d;

    logic              cdb_hit;
    logic [DEPTH-1:0]  match1, match2;
    logic [DEPTH-1:0]  rdy1, rdy2, entry_ready;

    logic              disp_found;
    logic [IDX_W-1:0]  disp_sel;
    logic              free_found;
    logic [IDX_W-1:0]  free_idx;

    logic              issue_fire;
    logic              disp_fire;

    logic              iss_match1, iss_match2;
    logic              iss_p1, iss_p2;
    logic [XLEN-1:0]   iss_v1, iss_v2;

    // CDB tag 0 means "no producer" and never wakes anything.
    assign cdb_hit = cdb_valid_i && (cdb_tag_i != '0);

    always_comb begin
        match1      = '0;
        match2      = '0;
        rdy1        = '0;
        rdy2        = '0;
        entry_ready = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            match1[i] = valid_q[i] && p1_q[i] && cdb_hit && (t1_q[i] == cdb_tag_i);
            match2[i] = valid_q[i] && p2_q[i] && cdb_hit && (t2_q[i] == cdb_tag_i);
`ifdef RS_WAKEUP_BYPASS_EN
            rdy1[i] = !p1_q[i] || match1[i];
            rdy2[i] = !p2_q[i] || match2[i];
`else
            rdy1[i] = !p1_q[i];
            rdy2[i] = !p2_q[i];
`endif
            entry_ready[i] = valid_q[i] && rdy1[i] &&
                             ((op_q[i][18:17] == FMT_I) || rdy2[i]);
        end
    end

    // Lowest-index pick: scan downwards so the last hit is the lowest index.
    always_comb begin
        disp_found = 1'b0;
        disp_sel   = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (entry_ready[i]) begin
                disp_found = 1'b1;
                disp_sel   = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Readiness is taken from pre-dispatch state, so a slot freed by dispatch
    // this cycle is not offered to issue until the next cycle.
    assign issue_ready_o = free_found;
    assign issue_fire    = issue_valid_i && free_found && !flush_i;
    assign disp_fire     = disp_found && disp_ready_i;

    assign disp_valid_o    = disp_found;
    assign disp_op_o       = op_q[disp_sel];
    assign disp_imm_o      = imm_q[disp_sel];
    assign disp_dest_tag_o = dest_q[disp_sel];
`ifdef RS_WAKEUP_BYPASS_EN
    assign disp_a_o = match1[disp_sel] ? cdb_value_i : v1_q[disp_sel];
    assign disp_b_o = match2[disp_sel] ? cdb_value_i : v2_q[disp_sel];
`else
    assign disp_a_o = v1_q[disp_sel];
    assign disp_b_o = v2_q[disp_sel];
`endif
    assign occupancy_o = occ_q;

    // Issue-time wakeup: a producer broadcasting in the issue cycle is caught
    // here, since the new entry is not yet visible to the per-entry match.
    assign iss_match1 = cdb_hit && (issue_rs1_tag_i == cdb_tag_i);
    assign iss_match2 = cdb_hit && (issue_rs2_tag_i == cdb_tag_i);
    assign iss_p1     = issue_rs1_virtual_i && !iss_match1;
    assign iss_p2     = issue_rs2_virtual_i && !iss_match2;
    assign iss_v1     = (issue_rs1_virtual_i && iss_match1) ? cdb_value_i : issue_rs1_value_i;
    assign iss_v2     = (issue_rs2_virtual_i && iss_match2) ? cdb_value_i : issue_rs2_value_i;

    always_comb begin
        valid_d = valid_q;
        occ_d   = occ_q;
        if (disp_fire) begin
            valid_d[disp_sel] = 1'b0;
        end
        if (issue_fire) begin
            valid_d[free_idx] = 1'b1;
        end
        unique case ({issue_fire, disp_fire})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
        if (flush_i) begin
            valid_d = '0;
            occ_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
    end

    // Payload: written on issue, otherwise operands capture matching CDB data.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (issue_fire && (free_idx == IDX_W'(i))) begin
                op_q[i]   <= issue_op_i;
                imm_q[i]  <= issue_imm_i;
                dest_q[i] <= issue_dest_tag_i;
                p1_q[i]   <= iss_p1;
                t1_q[i]   <= issue_rs1_tag_i;
                v1_q[i]   <= iss_v1;
                p2_q[i]   <= iss_p2;
                t2_q[i]   <= issue_rs2_tag_i;
                v2_q[i]   <= iss_v2;
            end else begin
                if (match1[i]) begin
                    p1_q[i] <= 1'b0;
                    v1_q[i] <= cdb_value_i;
                end
                if (match2[i]) begin
                    p2_q[i] <= 1'b0;
                    v2_q[i] <= cdb_value_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// -----------------------------------------------------------------------------
// tb_reservation_station
//
// Drives directed scenarios followed by randomized traffic into
// reservation_station (DEPTH=4, XLEN=64, TAG_W=3). Every cycle, the DUT
// outputs are compared against an entry-array model of the station.
// Honours RS_WAKEUP_BYPASS_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_reservation_station;

    localparam int DEPTH = 4;
    localparam int XLEN  = 64;
    localparam int TAG_W = 3;
    localparam logic [1:0] FMT_R = 2'b00;
    localparam logic [1:0] FMT_I = 2'b01;
`ifdef RS_WAKEUP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic             clk;
    logic             rst, flush;
    logic             issue_valid, issue_ready;
    logic [18:0]      issue_op;
    logic [11:0]      issue_imm;
    logic [TAG_W-1:0] issue_dest_tag;
    logic             rs1_virtual, rs2_virtual;
    logic [TAG_W-1:0] rs1_tag, rs2_tag;
    logic [XLEN-1:0]  rs1_value, rs2_value;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_value;
    logic             disp_valid, disp_ready;
    logic [18:0]      disp_op;
    logic [11:0]      disp_imm;
    logic [TAG_W-1:0] disp_dest_tag;
    logic [XLEN-1:0]  disp_a, disp_b;
    logic [2:0]       occupancy;

    reservation_station #(
        .DEPTH(DEPTH),
        .XLEN (XLEN),
        .TAG_W(TAG_W)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .flush_i            (flush),
        .issue_valid_i      (issue_valid),
        .issue_ready_o      (issue_ready),
        .issue_op_i         (issue_op),
        .issue_imm_i        (issue_imm),
        .issue_dest_tag_i   (issue_dest_tag),
        .issue_rs1_virtual_i(rs1_virtual),
        .issue_rs1_tag_i    (rs1_tag),
        .issue_rs1_value_i  (rs1_value),
        .issue_rs2_virtual_i(rs2_virtual),
        .issue_rs2_tag_i    (rs2_tag),
        .issue_rs2_value_i  (rs2_value),
        .cdb_valid_i        (cdb_valid),
        .cdb_tag_i          (cdb_tag),
        .cdb_value_i        (cdb_value),
        .disp_valid_o       (disp_valid),
        .disp_ready_i       (disp_ready),
        .disp_op_o          (disp_op),
        .disp_imm_o         (disp_imm),
        .disp_dest_tag_o    (disp_dest_tag),
        .disp_a_o           (disp_a),
        .disp_b_o           (disp_b),
        .occupancy_o        (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit               valid;
        logic [18:0]      op;
        logic [11:0]      imm;
        logic [TAG_W-1:0] dest;
        bit               p1;
        logic [TAG_W-1:0] t1;
        logic [XLEN-1:0]  v1;
        bit               p2;
        logic [TAG_W-1:0] t2;
        logic [XLEN-1:0]  v2;
    } ent_t;

    ent_t m[DEPTH];
    bit   known;
    bit   exp_dv;
    int   exp_sel;

    function automatic bit hits(input logic [TAG_W-1:0] t);
        return cdb_valid && (cdb_tag != 0) && (t == cdb_tag);
    endfunction

    function automatic bit entry_ready(input int i);
        bit a1;
        bit a2;
        a1 = !m[i].p1 || (BYPASS && hits(m[i].t1));
        a2 = !m[i].p2 || (BYPASS && hits(m[i].t2));
        return m[i].valid && a1 && (m[i].op[18:17] == FMT_I || a2);
    endfunction

    // Predict this cycle's outputs from the model and compare.
    task automatic eval_cycle();
        int   cnt;
        ent_t e;
        #1;
        exp_dv  = 1'b0;
        exp_sel = -1;
        cnt     = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!exp_dv && entry_ready(i)) begin
                exp_dv  = 1'b1;
                exp_sel = i;
            end
            if (m[i].valid) cnt++;
        end
        if (known) begin
            check_eq("issue_ready", 64'(issue_ready), 64'(cnt < DEPTH));
            check_eq("occupancy", 64'(occupancy), 64'(cnt));
            check_eq("disp_valid", 64'(disp_valid), 64'(exp_dv));
            if (exp_dv) begin
                e = m[exp_sel];
                check_eq("disp_op", 64'(disp_op), 64'(e.op));
                check_eq("disp_imm", 64'(disp_imm), 64'(e.imm));
                check_eq("disp_dest_tag", 64'(disp_dest_tag), 64'(e.dest));
                check_eq("disp_a", disp_a, e.p1 ? cdb_value : e.v1);
                if (e.op[18:17] != FMT_I) begin
                    check_eq("disp_b", disp_b, e.p2 ? cdb_value : e.v2);
                end
            end
        end
    endtask

    // Apply this cycle's inputs to the model at the rising edge.
    task automatic advance();
        int fi;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m[i].valid = 1'b0;
            known = 1'b1;
        end else if (known) begin
            fi = -1;
            for (int i = 0; i < DEPTH; i++) if (fi < 0 && !m[i].valid) fi = i;
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) m[i].valid = 1'b0;
            end else begin
                if (exp_dv && disp_ready) m[exp_sel].valid = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (m[i].valid && m[i].p1 && hits(m[i].t1)) begin
                        m[i].p1 = 1'b0;
                        m[i].v1 = cdb_value;
                    end
                    if (m[i].valid && m[i].p2 && hits(m[i].t2)) begin
                        m[i].p2 = 1'b0;
                        m[i].v2 = cdb_value;
                    end
                end
                if (issue_valid && fi >= 0) begin
                    m[fi].valid = 1'b1;
                    m[fi].op    = issue_op;
                    m[fi].imm   = issue_imm;
                    m[fi].dest  = issue_dest_tag;
                    m[fi].t1    = rs1_tag;
                    m[fi].t2    = rs2_tag;
                    m[fi].p1    = rs1_virtual && !hits(rs1_tag);
                    m[fi].p2    = rs2_virtual && !hits(rs2_tag);
                    m[fi].v1    = (rs1_virtual && hits(rs1_tag)) ? cdb_value : rs1_value;
                    m[fi].v2    = (rs2_virtual && hits(rs2_tag)) ? cdb_value : rs2_value;
                end
            end
        end
        #1;
    endtask

    task automatic step();
        eval_cycle();
        advance();
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [18:0] mk_op(input logic [1:0] fmt);
        logic [31:0] r;
        r = $urandom;
        return {fmt, r[16:0]};
    endfunction

    task automatic idle();
        rst         = 1'b0;
        flush       = 1'b0;
        issue_valid = 1'b0;
        rs1_virtual = 1'b0;
        rs2_virtual = 1'b0;
        cdb_valid   = 1'b0;
        cdb_tag     = '0;
        disp_ready  = 1'b0;
    endtask

    task automatic set_issue(input logic [18:0] op, input bit v1, input logic [TAG_W-1:0] t1,
                             input bit v2, input logic [TAG_W-1:0] t2);
        issue_valid    = 1'b1;
        issue_op       = op;
        issue_imm      = 12'($urandom);
        issue_dest_tag = TAG_W'($urandom);
        rs1_virtual    = v1;
        rs1_tag        = t1;
        rs1_value      = {$urandom, $urandom};
        rs2_virtual    = v2;
        rs2_tag        = t2;
        rs2_value      = {$urandom, $urandom};
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [18:0] op0, opy;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        known = 1'b0;
        issue_op = '0; issue_imm = '0; issue_dest_tag = '0;
        rs1_tag = '0; rs2_tag = '0; rs1_value = '0; rs2_value = '0; cdb_value = '0;
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        check_eq("rst_issue_ready", 64'(issue_ready), 64'd1);
        check_eq("rst_occupancy", 64'(occupancy), 64'd0);
        check_eq("rst_disp_valid", 64'(disp_valid), 64'd0);

        // Fill the station with ready ops while the FU stalls.
        op0 = mk_op(FMT_R);
        for (int k = 0; k < DEPTH; k++) begin
            idle();
            set_issue((k == 0) ? op0 : mk_op(FMT_R), 1'b0, 3'd0, 1'b0, 3'd0);
            step();
        end
        idle();
        #1;
        check_eq("full_issue_ready", 64'(issue_ready), 64'd0);
        check_eq("full_occupancy", 64'(occupancy), 64'd4);
        check_eq("full_disp_op", 64'(disp_op), 64'(op0));

        // Full + simultaneous dispatch: issue refused, slot reused next cycle.
        set_issue(mk_op(FMT_R), 1'b0, 3'd0, 1'b0, 3'd0);
        disp_ready = 1'b1;
        step();
        opy = mk_op(FMT_R);
        idle();
        set_issue(opy, 1'b0, 3'd0, 1'b0, 3'd0);
        #1;
        check_eq("freed_occupancy", 64'(occupancy), 64'd3);
        check_eq("freed_issue_ready", 64'(issue_ready), 64'd1);
        step();
        idle();
        #1;
        check_eq("refill_occupancy", 64'(occupancy), 64'd4);
        check_eq("refill_disp_op", 64'(disp_op), 64'(opy));

        // rs1 pending on tag 5, woken two cycles later.
        do_reset();
        set_issue(mk_op(FMT_R), 1'b1, 3'd5, 1'b0, 3'd0);
        step();
        idle();
        step();
        idle();
        cdb_valid = 1'b1;
        cdb_tag   = 3'd5;
        cdb_value = 64'h1234;
        #1;
        check_eq("wake_cycle_disp_valid", 64'(disp_valid), 64'(BYPASS));
        step();
        idle();
        #1;
        check_eq("woken_disp_valid", 64'(disp_valid), 64'd1);
        check_eq("woken_disp_a", disp_a, 64'h1234);
        disp_ready = 1'b1;
        step();

        // Wakeup coinciding with issue.
        do_reset();
        set_issue(mk_op(FMT_R), 1'b1, 3'd3, 1'b0, 3'd0);
        cdb_valid = 1'b1;
        cdb_tag   = 3'd3;
        cdb_value = 64'hAA;
        step();
        idle();
        #1;
        check_eq("issue_wake_disp_valid", 64'(disp_valid), 64'd1);
        check_eq("issue_wake_disp_a", disp_a, 64'hAA);
        disp_ready = 1'b1;
        step();

        // Flush together with a CDB wakeup.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            idle();
            set_issue(mk_op(FMT_R), 1'b1, 3'd2, 1'b0, 3'd0);
            step();
        end
        idle();
        flush     = 1'b1;
        cdb_valid = 1'b1;
        cdb_tag   = 3'd2;
        cdb_value = 64'h77;
        step();
        idle();
        disp_ready = 1'b1;
        #1;
        check_eq("flush_occupancy", 64'(occupancy), 64'd0);
        check_eq("flush_disp_valid", 64'(disp_valid), 64'd0);
        step();
        step();

        // Tag 0 never wakes.
        do_reset();
        set_issue(mk_op(FMT_R), 1'b1, 3'd0, 1'b0, 3'd0);
        step();
        idle();
        cdb_valid = 1'b1;
        cdb_tag   = 3'd0;
        cdb_value = 64'h55;
        #1;
        check_eq("tag0_disp_valid", 64'(disp_valid), 64'd0);
        step();
        idle();
        #1;
        check_eq("tag0_after_disp_valid", 64'(disp_valid), 64'd0);
        check_eq("tag0_occupancy", 64'(occupancy), 64'd1);
        step();

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 49) == 0);
            set_issue(mk_op(2'($urandom)), 1'($urandom), 3'd0, 1'($urandom), 3'd0);
            issue_valid = ($urandom_range(0, 3) != 0);
            rs1_tag     = ($urandom_range(0, 15) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            rs2_tag     = ($urandom_range(0, 15) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            cdb_valid   = 1'($urandom);
            cdb_tag     = 3'($urandom_range(0, 7));
            cdb_value   = {$urandom, $urandom};
            disp_ready  = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
